ag_io_ctrl: RTL and testbench

- Parametrised Agat I/O page controller for the $C0xx soft-switch area, decoded from the 6502 bus.
- Provides a keyboard FIFO, read at $C00x and popped at $C01x.
- Provides tape/beep toggles at $C02x/$C03x and a vsync-derived NMI timer, enabled at $C04x and disabled at $C05x.
- Provides a video mode latch at $C7xx and a boot-hold flag.
- Sits beside the CPU core in the top level and drives the shared read bus.

---
 rtl/ag_io_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ag_io_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ag_io_ctrl.sv
// rtl/ag_io_ctrl.sv - Agat $C0xx I/O page controller: keyboard FIFO, tape/beep, NMI timer, vmode latch
// Optional button key injection is enabled by defining AG_IO_BTN_INJECT_EN.
module ag_io_ctrl #(
  parameter int KEY_DEPTH = 4,
  parameter int TIMER_DIV = 1,
  parameter int NMI_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic        read,
  input  logic        bus_stb,
  output logic [7:0]  DI_out,
  output logic        DI_oe,
  input  logic [7:0]  key_data,
  input  logic        key_valid,
  output logic        key_ovf,
  input  logic        vsync,
  output logic        nmi,
  output logic [7:0]  vmode,
  output logic        tape_out,
  output logic        beep,
  output logic        reset_hold,
  input  logic [3:0]  btns
);
  localparam int AW = $clog2(KEY_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [KEY_DEPTH];
  logic [7:0]    mem_d [KEY_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    last_key_q, last_key_d;
  logic          key_ovf_q, key_ovf_d;
  logic [7:0]    vmode_q, vmode_d;
  logic          tape_q, tape_d, beep_q, beep_d;
  logic          timer_en_q, timer_en_d;
  logic [7:0]    presc_q, presc_d;
  logic [7:0]    nmi_cnt_q, nmi_cnt_d;
  logic          nmi_q, nmi_d;
  logic          hold_q, hold_d;
  logic          vs_s1_q, vs_s2_q, vs_prev_q;

  logic          is_c0, is_c7, acc_c00, acc_c01, acc_c02, acc_c03, acc_c04, acc_c05;
  logic          fifo_empty, fifo_full, pop, push, drop, vs_rise, trig;
  logic          push_req;
  logic [7:0]    push_data;

  assign is_c0   = bus_stb && (AB[15:8] == 8'hC0);
  assign is_c7   = bus_stb && (AB[15:8] == 8'hC7);
  assign acc_c00 = is_c0 && (AB[7:4] == 4'h0);
  assign acc_c01 = is_c0 && (AB[7:4] == 4'h1);
  assign acc_c02 = is_c0 && (AB[7:4] == 4'h2);
  assign acc_c03 = is_c0 && (AB[7:4] == 4'h3);
  assign acc_c04 = is_c0 && (AB[7:4] == 4'h4);
  assign acc_c05 = is_c0 && (AB[7:4] == 4'h5);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(KEY_DEPTH));
  assign vs_rise    = vs_s2_q & ~vs_prev_q;

  // Read data is combinational so the CPU sees it within the same bus cycle.
  assign DI_oe  = acc_c00 && read;
  assign DI_out = fifo_empty ? {1'b0, last_key_q[6:0]} : mem_q[rd_ptr_q];

`ifdef AG_IO_BTN_INJECT_EN
  logic [3:0] btn_s1_q, btn_s2_q, btn_prev_q, btn_rise;
  logic [7:0] btn_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= btns;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign btn_rise = btn_s2_q & ~btn_prev_q;

  always_comb begin
    btn_code = 8'h00;
    if      (btn_rise[2]) btn_code = 8'h8D;
    else if (btn_rise[0]) btn_code = 8'h9A;
    else if (btn_rise[1]) btn_code = 8'hA0;
    else if (btn_rise[3]) btn_code = 8'h99;
  end

  // A real key in the same cycle wins; the button event is simply discarded.
  assign push_req  = key_valid || (btn_rise != 4'b0000);
  assign push_data = key_valid ? key_data : btn_code;
`else
  logic unused_btns;
  assign unused_btns = ^btns;
  assign push_req    = key_valid;
  assign push_data   = key_data;
`endif

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    last_key_d = last_key_q;
    key_ovf_d  = key_ovf_q;
    vmode_d    = vmode_q;
    tape_d     = tape_q;
    beep_d     = beep_q;
    timer_en_d = timer_en_q;
    presc_d    = presc_q;
    nmi_cnt_d  = nmi_cnt_q;
    hold_d     = hold_q;

    pop  = acc_c01 && !fifo_empty;
    push = push_req && (!fifo_full || pop);
    drop = push_req && fifo_full && !pop;

    if (pop) begin
      last_key_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    if (acc_c01)   key_ovf_d = 1'b0;
    else if (drop) key_ovf_d = 1'b1;

    if (acc_c02) tape_d = ~tape_q;
    if (acc_c03) beep_d = ~beep_q;
    if (is_c7)   vmode_d = AB[7:0];

    if (vs_rise) hold_d = 1'b0;

    // Prescaler counts vsync rises; the TIMER_DIV-th rise wraps it and fires.
    trig = timer_en_q && vs_rise && (presc_q == 8'(TIMER_DIV - 1));
    if (timer_en_q && vs_rise) presc_d = trig ? 8'd0 : presc_q + 8'd1;
    if (acc_c04) begin
      timer_en_d = 1'b1;
      presc_d    = 8'd0;
    end
    if (acc_c05) timer_en_d = 1'b0;

    if (trig)                   nmi_cnt_d = 8'(NMI_WIDTH);
    else if (nmi_cnt_q != 8'd0) nmi_cnt_d = nmi_cnt_q - 8'd1;
    if (acc_c05)                nmi_cnt_d = 8'd0;
    nmi_d = (nmi_cnt_d != 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      last_key_q <= 8'h00;
      key_ovf_q  <= 1'b0;
      vmode_q    <= 8'h00;
      tape_q     <= 1'b0;
      beep_q     <= 1'b0;
      timer_en_q <= 1'b0;
      presc_q    <= 8'd0;
      nmi_cnt_q  <= 8'd0;
      nmi_q      <= 1'b0;
      hold_q     <= 1'b1;
      vs_s1_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      last_key_q <= last_key_d;
      key_ovf_q  <= key_ovf_d;
      vmode_q    <= vmode_d;
      tape_q     <= tape_d;
      beep_q     <= beep_d;
      timer_en_q <= timer_en_d;
      presc_q    <= presc_d;
      nmi_cnt_q  <= nmi_cnt_d;
      nmi_q      <= nmi_d;
      hold_q     <= hold_d;
      vs_s1_q    <= vsync;
      vs_s2_q    <= vs_s1_q;
      vs_prev_q  <= vs_s2_q;
    end
  end

  assign key_ovf    = key_ovf_q;
  assign vmode      = vmode_q;
  assign tape_out   = tape_q;
  assign beep       = beep_q;
  assign nmi        = nmi_q;
  assign reset_hold = hold_q;
endmodule

// File: tb/tb_ag_io_ctrl.sv
// tb/tb_ag_io_ctrl.sv - self-checking bench for ag_io_ctrl against a queue-based behavioural model
module tb_ag_io_ctrl;
  localparam int KD = 4;
  localparam int TD = 3;
  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] AB = '0;
  logic        read = 1'b0, bus_stb = 1'b0;
  logic [7:0]  DI_out;
  logic        DI_oe;
  logic [7:0]  key_data = '0;
  logic        key_valid = 1'b0;
  logic        key_ovf;
  logic        vsync = 1'b0;
  logic        nmi;
  logic [7:0]  vmode;
  logic        tape_out, beep, reset_hold;
  logic [3:0]  btns = '0;

  always #10 clk = ~clk;

  ag_io_ctrl #(.KEY_DEPTH(KD), .TIMER_DIV(TD), .NMI_WIDTH(NW)) dut (
    .clk(clk), .reset_n(reset_n), .AB(AB), .read(read), .bus_stb(bus_stb),
    .DI_out(DI_out), .DI_oe(DI_oe), .key_data(key_data), .key_valid(key_valid),
    .key_ovf(key_ovf), .vsync(vsync), .nmi(nmi), .vmode(vmode),
    .tape_out(tape_out), .beep(beep), .reset_hold(reset_hold), .btns(btns)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as a queue, timer as "count rises since enable".
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00, m_vmode = 8'h00;
  logic       m_ovf = 1'b0, m_tape = 1'b0, m_beep = 1'b0, m_hold = 1'b1, m_en = 1'b0;
  int         m_rises = 0, m_nmi_left = 0;
  logic       vh1 = 1'b0, vh2 = 1'b0, vh3 = 1'b0;
  logic       m_c0, m_rise, m_trig, m_pop, m_req;
  logic [7:0] m_pdata;
  logic [3:0] bh1 = '0, bh2 = '0, bh3 = '0, m_brise;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_last = 8'h00; m_vmode = 8'h00; m_ovf = 1'b0; m_tape = 1'b0; m_beep = 1'b0;
      m_hold = 1'b1; m_en = 1'b0; m_rises = 0; m_nmi_left = 0;
      vh1 = 1'b0; vh2 = 1'b0; vh3 = 1'b0; bh1 = '0; bh2 = '0; bh3 = '0;
    end else begin
      m_c0 = bus_stb && (AB[15:8] == 8'hC0);
      // vsync is seen as a rise two clocks after it is first sampled high
      m_rise = vh2 && !vh3;
      vh3 = vh2; vh2 = vh1; vh1 = vsync;
      if (m_rise) m_hold = 1'b0;
      m_trig = 1'b0;
      if (m_en && m_rise) begin
        m_rises++;
        if (m_rises == TD) begin m_rises = 0; m_trig = 1'b1; end
      end
      if (m_trig) m_nmi_left = NW;
      else if (m_nmi_left > 0) m_nmi_left--;
      if (m_c0 && AB[7:4] == 4'h5) begin m_en = 1'b0; m_nmi_left = 0; end
      if (m_c0 && AB[7:4] == 4'h4) begin m_en = 1'b1; m_rises = 0; end

      m_req = key_valid; m_pdata = key_data;
`ifdef AG_IO_BTN_INJECT_EN
      m_brise = bh2 & ~bh3;
      bh3 = bh2; bh2 = bh1; bh1 = btns;
      if (!key_valid && m_brise != 0) begin
        m_req = 1'b1;
        m_pdata = m_brise[2] ? 8'h8D : m_brise[0] ? 8'h9A : m_brise[1] ? 8'hA0 : 8'h99;
      end
`endif
      m_pop = m_c0 && AB[7:4] == 4'h1 && mq.size() > 0;
      if (m_req && mq.size() == KD && !m_pop) begin
        if (!(m_c0 && AB[7:4] == 4'h1)) m_ovf = 1'b1;
      end else if (m_req) begin
        if (m_pop) m_last = mq.pop_front();
        mq.push_back(m_pdata);
      end else if (m_pop) m_last = mq.pop_front();
      if (m_c0 && AB[7:4] == 4'h1) m_ovf = 1'b0;
      if (m_c0 && AB[7:4] == 4'h2) m_tape = !m_tape;
      if (m_c0 && AB[7:4] == 4'h3) m_beep = !m_beep;
      if (bus_stb && AB[15:8] == 8'hC7) m_vmode = AB[7:0];
    end
  end

  always @(negedge clk) begin
    logic exp_oe;
    exp_oe = bus_stb && read && (AB[15:4] == 12'hC00);
    check("m_key_ovf", 16'(key_ovf), 16'(m_ovf));
    check("m_nmi", 16'(nmi), 16'(m_nmi_left > 0));
    check("m_vmode", 16'(vmode), 16'(m_vmode));
    check("m_tape", 16'(tape_out), 16'(m_tape));
    check("m_beep", 16'(beep), 16'(m_beep));
    check("m_hold", 16'(reset_hold), 16'(m_hold));
    check("m_di_oe", 16'(DI_oe), 16'(exp_oe));
    if (exp_oe)
      check("m_di_out", 16'(DI_out), 16'((mq.size() > 0) ? mq[0] : {1'b0, m_last[6:0]}));
  end

  int   run = 0, pulses = 0;
  logic len_chk = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) run = 0;
    else if (nmi) run++;
    else if (run > 0) begin
      pulses++;
      if (len_chk) check("nmi_width", 16'(run), 16'(NW));
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [7:0] k);
    key_data = k; key_valid = 1'b1; tick(); key_valid = 1'b0;
  endtask

  task automatic acc(input logic [15:0] a, input logic rd);
    AB = a; read = rd; bus_stb = 1'b1; tick(); bus_stb = 1'b0; read = 1'b0; AB = '0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] exp);
    AB = 16'hC000; read = 1'b1; bus_stb = 1'b1; #1;
    check(name, 16'(DI_out), 16'(exp));
    check({name, "_oe"}, 16'(DI_oe), 16'd1);
    tick(); bus_stb = 1'b0; read = 1'b0; AB = '0;
  endtask

  task automatic vrise();
    vsync = 1'b1; tick(); tick(); vsync = 1'b0; tick(); tick();
  endtask

  logic [7:0] drain [4] = '{8'h83, 8'h84, 8'h85, 8'h86};

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_hold", 16'(reset_hold), 16'd1);
    check("rst_nmi", 16'(nmi), 16'd0);

    push(8'hC1); push(8'hC2);
    rd_chk("rd_c1", 8'hC1);
    acc(16'hC010, 1'b1);
    rd_chk("rd_c2", 8'hC2);
    acc(16'hC010, 1'b0);
    rd_chk("rd_empty", 8'h42);

    for (int k = 0; k < 5; k++) push(8'h81 + 8'(k));
    check("ovf_set", 16'(key_ovf), 16'd1);
    rd_chk("ovf_head", 8'h81);
    acc(16'hC010, 1'b0);
    check("ovf_clr", 16'(key_ovf), 16'd0);
    push(8'h85);
    key_data = 8'h86; key_valid = 1'b1; AB = 16'hC010; bus_stb = 1'b1; read = 1'b0;
    tick();
    key_valid = 1'b0; bus_stb = 1'b0; AB = '0;
    check("full_pushpop_ovf", 16'(key_ovf), 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd_chk("drain", drain[i]);
      acc(16'hC010, 1'b1);
    end
    rd_chk("drain_last", 8'h06);

    acc(16'hC020, 1'b1); acc(16'hC02F, 1'b0); acc(16'hC030, 1'b0);
    check("tape", 16'(tape_out), 16'd0);
    check("beep", 16'(beep), 16'd1);
    acc(16'hC7A5, 1'b1);
    check("vmode_rd", 16'(vmode), 16'h00A5);
    acc(16'hC73C, 1'b0);
    check("vmode_wr1", 16'(vmode), 16'h003C);
    acc(16'hC7A5, 1'b0);
    check("vmode_wr2", 16'(vmode), 16'h00A5);

    acc(16'hC040, 1'b0);
    len_chk = 1'b1;
    repeat (6) vrise();
    repeat (10) tick();
    check("pulse_count", 16'(pulses), 16'd2);
    check("hold_cleared", 16'(reset_hold), 16'd0);
    repeat (3) vrise();
    check("nmi_mid", 16'(nmi), 16'd1);
    len_chk = 1'b0;
    acc(16'hC050, 1'b0);
    check("nmi_cancel", 16'(nmi), 16'd0);

    acc(16'hC040, 1'b0);
    push(8'h55);
    acc(16'hC021, 1'b0);
    repeat (3) vrise();
    check("pre_rst_nmi", 16'(nmi), 16'd1);
    check("pre_rst_hold", 16'(reset_hold), 16'd0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_nmi", 16'(nmi), 16'd0);
    check("arst_hold", 16'(reset_hold), 16'd1);
    check("arst_vmode", 16'(vmode), 16'd0);
    check("arst_tape", 16'(tape_out), 16'd0);
    check("arst_beep", 16'(beep), 16'd0);
    AB = 16'hC000; read = 1'b1; bus_stb = 1'b1; #1;
    check("arst_fifo", 16'(DI_out), 16'd0);
    bus_stb = 1'b0; read = 1'b0; AB = '0;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("hold_after_rst", 16'(reset_hold), 16'd1);
    vrise();
    check("hold_after_vs", 16'(reset_hold), 16'd0);

`ifdef AG_IO_BTN_INJECT_EN
    btns = 4'b0101;
    repeat (6) tick();
    rd_chk("btn_code", 8'h8D);
    acc(16'hC010, 1'b0);
    repeat (6) tick();
    rd_chk("btn_norepeat", 8'h0D);
    btns = 4'b0000;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
